// File: rtl/seg7_para_bin_if.sv
// Handshake and digit bus between a requester and the 7-segment to binary converter.
// Segment patterns are {g,f,e,d,c,b,a}; result and status come back on the same bus.
interface seg7_para_bin_if;
  logic       start;
  logic [6:0] seg_centenas;
  logic [6:0] seg_dezenas;
  logic [6:0] seg_unidades;
  logic       busy;
  logic       done;
  logic       erro;
  logic [9:0] bin_out;

  modport master (
    output start, seg_centenas, seg_dezenas, seg_unidades,
    input  busy, done, erro, bin_out
  );
  modport slave (
    input  start, seg_centenas, seg_dezenas, seg_unidades,
    output busy, done, erro, bin_out
  );
endinterface

// File: rtl/seg7_para_bin.sv
// Decodes three 7-segment digits to BCD and converts the 3-digit value to binary
// with a 10-step reverse double-dabble; start/done handshake, one job at a time.

module seg7_dec_lane (
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       vld
);
  always_comb begin
    bcd = 4'd0;
    vld = 1'b1;
    case (seg)
      7'h3F: bcd = 4'd0;
      7'h06: bcd = 4'd1;
      7'h5B: bcd = 4'd2;
      7'h4F: bcd = 4'd3;
      7'h66: bcd = 4'd4;
      7'h6D: bcd = 4'd5;
      7'h7D: bcd = 4'd6;
      7'h07: bcd = 4'd7;
      7'h7F: bcd = 4'd8;
      7'h6F: bcd = 4'd9;
      default: vld = 1'b0;
    endcase
  end
endmodule

module seg7_para_bin #(
  parameter int unsigned MAX_VALOR       = 999,
  parameter bit          SEG_ATIVO_BAIXO = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  seg7_para_bin_if.slave bus
);
  localparam int          NUM_DIGITS = 3;
  localparam int          ITERS      = 10;
  localparam logic [9:0]  MAX_10     = 10'(MAX_VALOR);

  typedef enum logic [1:0] {IDLE, DECODE, CONVERT, FIM} state_t;

  state_t                         state_q, state_d;
  logic [NUM_DIGITS-1:0][6:0]     seg_in, seg_q;
  logic [NUM_DIGITS-1:0][3:0]     bcd;
  logic [NUM_DIGITS-1:0]          dig_vld;
  logic [4*NUM_DIGITS+9:0]        sr_q, sr_shift, sr_adj;
  logic [3:0]                     iter_q;
  logic                           erro_int_q, done_q, erro_q;
  logic [9:0]                     bin_q;

  // index 2 = centenas, so {bcd} lands hundreds in the top nibble
  assign seg_in = {bus.seg_centenas, bus.seg_dezenas, bus.seg_unidades};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_dec_lane u_dec (.seg(seg_q[g]), .bcd(bcd[g]), .vld(dig_vld[g]));
  end

  // Reverse double-dabble step: shift right, then pull 3 out of any nibble that
  // received a carried-in 8 (nibble >= 8 means its MSB is set).
  always_comb begin
    sr_shift = sr_q >> 1;
    sr_adj   = sr_shift;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sr_shift[10+4*i+3]) sr_adj[10+4*i +: 4] = sr_shift[10+4*i +: 4] - 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DECODE;
      DECODE:  state_d = (&dig_vld) ? CONVERT : FIM;
      CONVERT: if (iter_q == 4'(ITERS-1)) state_d = FIM;
      FIM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      sr_q       <= '0;
      iter_q     <= 4'd0;
      erro_int_q <= 1'b0;
      done_q     <= 1'b0;
      erro_q     <= 1'b0;
      bin_q      <= 10'd0;
    end else begin
      done_q <= 1'b0;
      erro_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          seg_q      <= SEG_ATIVO_BAIXO ? ~seg_in : seg_in;
          erro_int_q <= 1'b0;
        end
        DECODE: begin
          if (&dig_vld) begin
            sr_q   <= {bcd, 10'd0};
            iter_q <= 4'd0;
          end else begin
            erro_int_q <= 1'b1;
          end
        end
        CONVERT: begin
          sr_q   <= sr_adj;
          iter_q <= iter_q + 4'd1;
        end
        FIM: begin
          done_q <= 1'b1;
          if (!erro_int_q && sr_q[9:0] <= MAX_10) bin_q  <= sr_q[9:0];
          else                                    erro_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.erro    = erro_q;
  assign bus.bin_out = bin_q;
endmodule
